// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared encodings and lane helpers for the load/store unit
package load_store_unit_pkg;

  // Funct3 encodings for loads and stores
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // FaultCause codes
  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_RWAIT = 2'd2,
    ST_DONE  = 2'd3
  } lsu_state_e;

  // Only one of re/we may be set, and Funct3 must name a real access of that kind
  function automatic logic access_legal(input logic re, input logic we, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    if (re && !we) begin
      ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
    end else if (we && !re) begin
      ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    end
    return ok;
  endfunction

  // Size lives in f3[1:0]: 00 byte, 01 half, 10 word
  function automatic logic access_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    case (f3[1:0])
      2'b01:   bad = off[0];
      2'b10:   bad = (off != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Byte enables for an aligned access of the given size at the given offset
  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate the store datum across every lane it could occupy
  function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] d;
    case (f3[1:0])
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - extracts and sign/zero-extends the loaded byte/halfword/word
module load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane, then extend according to Funct3
  always_comb begin
    case (offset_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  data_o = {24'd0, byte_sel};
      F3_LHU:  data_o = {16'd0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-side load/store responder with alignment and timeout faults
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemoryRE,
  input  logic              MemoryWE,
  input  logic [2:0]        Funct3,
  input  logic [31:0]       Addr,
  input  logic [31:0]       WData,
  output logic              Stall,
  output logic              Done,
  output logic [31:0]       LoadData,
  output logic              Fault,
  output logic [1:0]        FaultCause,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        cause_q, cause_d;
  logic [31:0]       ldata_q, ldata_d;
  logic              mem_req_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [3:0]        mem_be_q;
  logic [31:0]       mem_wdata_q;
  logic [2:0]        funct3_q;
  logic [1:0]        off_q;
  logic [31:0]       align_data;
  logic              request;
  logic              timed_out;

  load_align u_align (
    .rdata_i  (mem_rdata),
    .funct3_i (funct3_q),
    .offset_i (off_q),
    .data_o   (align_data)
  );

  assign request   = MemoryRE | MemoryWE;
  assign timed_out = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Next-state, fault classification and the combinational stall
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    ldata_d = ldata_q;
    Stall   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        Stall = request;
        if (request) begin
          if (!access_legal(MemoryRE, MemoryWE, Funct3)) begin
            state_d = ST_DONE;
            cause_d = CAUSE_ILLEGAL;
            ldata_d = 32'd0;
          end else if (access_misaligned(Funct3, Addr[1:0])) begin
            state_d = ST_DONE;
            cause_d = CAUSE_MISALIGN;
            ldata_d = 32'd0;
          end else begin
            state_d = ST_REQ;
            cnt_d   = '0;
          end
        end
      end
      ST_REQ: begin
        Stall = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_gnt) begin
          if (mem_we_q) begin
            state_d = ST_DONE;
            cause_d = CAUSE_NONE;
            ldata_d = 32'd0;
          end else begin
            state_d = ST_RWAIT;
          end
        end else if (timed_out) begin
          state_d = ST_DONE;
          cause_d = CAUSE_TIMEOUT;
          ldata_d = 32'd0;
        end
      end
      ST_RWAIT: begin
        Stall = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_rvalid) begin
          state_d = ST_DONE;
          cause_d = CAUSE_NONE;
          ldata_d = align_data;
        end else if (timed_out) begin
          state_d = ST_DONE;
          cause_d = CAUSE_TIMEOUT;
          ldata_d = 32'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state, timeout counter and completion result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cause_q <= CAUSE_NONE;
      ldata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      ldata_q <= ldata_d;
    end
  end

  // Backend request fields: captured on IDLE->REQ, held through REQ, zero otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'd0;
      mem_wdata_q <= 32'd0;
      funct3_q    <= 3'd0;
      off_q       <= 2'd0;
    end else if (state_q == ST_IDLE && state_d == ST_REQ) begin
      mem_req_q   <= 1'b1;
      mem_we_q    <= MemoryWE;
      mem_addr_q  <= Addr[ADDR_W+1:2];
      mem_be_q    <= lane_be(Funct3, Addr[1:0]);
      mem_wdata_q <= MemoryWE ? lane_wdata(Funct3, WData) : 32'd0;
      funct3_q    <= Funct3;
      off_q       <= Addr[1:0];
    end else if (state_d != ST_REQ) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'd0;
      mem_wdata_q <= 32'd0;
    end
  end

  assign Done       = (state_q == ST_DONE);
  assign Fault      = Done & (cause_q != CAUSE_NONE);
  assign FaultCause = Done ? cause_q : CAUSE_NONE;
  assign LoadData   = Done ? ldata_q : 32'd0;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemoryRE, MemoryWE;
  logic [2:0]  Funct3;
  logic [31:0] Addr, WData;
  logic        Stall, Done, Fault;
  logic [31:0] LoadData;
  logic [1:0]  FaultCause;
  logic        mem_req, mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  int          r_cyc;
  bit          r_done;
  logic [31:0] r_ld;
  logic        r_fault;
  logic [1:0]  r_cause;
  bit          r_saw_req;
  logic [29:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic        r_we;
  int          r_stall;
  logic        r_stall_at_done;

  load_store_unit #(.TIMEOUT_CYCLES(4), .ADDR_W(30)) dut (
    .clk(clk), .rst(rst), .MemoryRE(MemoryRE), .MemoryWE(MemoryWE),
    .Funct3(Funct3), .Addr(Addr), .WData(WData), .Stall(Stall), .Done(Done),
    .LoadData(LoadData), .Fault(Fault), .FaultCause(FaultCause),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access from IDLE; gnt/rvalid on their first possible cycle unless rvalid withheld
  task automatic access(input logic re, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input bit hold_rv);
    bit pend;
    pend = 0; r_done = 0; r_cyc = -1; r_saw_req = 0; r_stall = 0;
    r_addr = '0; r_be = '0; r_wdata = '0; r_we = 0; r_ld = '0;
    r_fault = 0; r_cause = 0; r_stall_at_done = 0;
    MemoryRE = re; MemoryWE = we; Funct3 = f3; Addr = a; WData = wd; mem_rdata = rd;
    for (int c = 0; c < 40 && !r_done; c++) begin
      mem_gnt    = mem_req;
      mem_rvalid = pend && !hold_rv;
      #1;
      if (mem_req) begin
        r_saw_req = 1; r_addr = mem_addr; r_be = mem_be; r_wdata = mem_wdata; r_we = mem_we;
      end
      if (Done) begin
        r_done = 1; r_cyc = c; r_ld = LoadData; r_fault = Fault; r_cause = FaultCause;
        r_stall_at_done = Stall;
      end else if (Stall) begin
        r_stall++;
      end
      if (mem_rvalid) pend = 0;
      if (mem_req && !mem_we) pend = 1;
      if (!r_done) tick();
    end
    MemoryRE = 0; MemoryWE = 0; mem_gnt = 0; mem_rvalid = 0;
    chk("done_seen", 32'(r_done), 32'd1);
    tick();
  endtask

  initial begin
    rst = 1; MemoryRE = 0; MemoryWE = 0; Funct3 = 0; Addr = 0; WData = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    tick(); tick();
    chk("rst_stall", 32'(Stall), 0);
    chk("rst_done", 32'(Done), 0);
    chk("rst_fault", 32'(Fault), 0);
    chk("rst_cause", 32'(FaultCause), 0);
    chk("rst_ldata", LoadData, 0);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_be", 32'(mem_be), 0);
    chk("rst_wdata", mem_wdata, 0);
    rst = 0;
    tick();

    // SW 0x100
    access(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0);
    chk("sw_cyc", r_cyc, 2);
    chk("sw_addr", 32'(r_addr), 32'h40);
    chk("sw_be", 32'(r_be), 32'hF);
    chk("sw_wdata", r_wdata, 32'hDEADBEEF);
    chk("sw_we", 32'(r_we), 1);
    chk("sw_fault", 32'(r_fault), 0);
    chk("sw_stall", r_stall, 2);
    chk("sw_stall_done", 32'(r_stall_at_done), 0);

    // SB 0x103
    access(0, 1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 0);
    chk("sb_be", 32'(r_be), 32'h8);
    chk("sb_wdata", r_wdata, 32'hA5A5A5A5);
    chk("sb_cyc", r_cyc, 2);

    // SH 0x002
    access(0, 1, 3'b001, 32'h002, 32'h1234BEEF, 32'h0, 0);
    chk("sh_be", 32'(r_be), 32'hC);
    chk("sh_wdata", r_wdata, 32'hBEEFBEEF);

    // Loads from 0x80F17F00
    access(1, 0, 3'b000, 32'h001, 32'h0, 32'h80F17F00, 0);
    chk("lb1_data", r_ld, 32'h0000007F);
    chk("lb1_cyc", r_cyc, 3);
    chk("lb1_stall", r_stall, 3);
    chk("lb1_be", 32'(r_be), 32'h2);
    access(1, 0, 3'b000, 32'h003, 32'h0, 32'h80F17F00, 0);
    chk("lb3_data", r_ld, 32'hFFFFFF80);
    chk("lb3_cyc", r_cyc, 3);
    access(1, 0, 3'b101, 32'h002, 32'h0, 32'h80F17F00, 0);
    chk("lhu2_data", r_ld, 32'h000080F1);
    chk("lhu2_cyc", r_cyc, 3);
    access(1, 0, 3'b001, 32'h002, 32'h0, 32'h80F17F00, 0);
    chk("lh2_data", r_ld, 32'hFFFF80F1);
    chk("lh2_cyc", r_cyc, 3);
    chk("lh2_fault", 32'(r_fault), 0);

    // Misaligned LW
    access(1, 0, 3'b010, 32'h102, 32'h0, 32'hFFFFFFFF, 0);
    chk("mis_cyc", r_cyc, 1);
    chk("mis_fault", 32'(r_fault), 1);
    chk("mis_cause", 32'(r_cause), 1);
    chk("mis_req", 32'(r_saw_req), 0);
    chk("mis_ldata", r_ld, 0);

    // Misaligned SH
    access(0, 1, 3'b001, 32'h001, 32'h0, 32'h0, 0);
    chk("mish_cause", 32'(r_cause), 1);
    chk("mish_req", 32'(r_saw_req), 0);

    // RE and WE together
    access(1, 1, 3'b010, 32'h000, 32'h0, 32'h0, 0);
    chk("rewe_cyc", r_cyc, 1);
    chk("rewe_cause", 32'(r_cause), 3);
    chk("rewe_req", 32'(r_saw_req), 0);

    // Illegal load Funct3
    access(1, 0, 3'b011, 32'h000, 32'h0, 32'h0, 0);
    chk("f3_cause", 32'(r_cause), 3);
    chk("f3_fault", 32'(r_fault), 1);

    // Timeout: granted load, rvalid withheld
    access(1, 0, 3'b010, 32'h000, 32'h0, 32'h11111111, 1);
    chk("to_cyc", r_cyc, 5);
    chk("to_cause", 32'(r_cause), 2);
    chk("to_fault", 32'(r_fault), 1);
    chk("to_ldata", r_ld, 0);
    mem_rvalid = 1; mem_rdata = 32'h22222222;
    #1;
    chk("late_rv_stall", 32'(Stall), 0);
    tick();
    mem_rvalid = 0;
    #1;
    chk("late_rv_done", 32'(Done), 0);
    access(1, 0, 3'b010, 32'h004, 32'h0, 32'h12345678, 0);
    chk("after_to_data", r_ld, 32'h12345678);
    chk("after_to_cyc", r_cyc, 3);
    chk("after_to_fault", 32'(r_fault), 0);

    // Reset during RWAIT
    MemoryRE = 1; Funct3 = 3'b010; Addr = 32'h8;
    tick();
    mem_gnt = 1;
    #1;
    chk("rw_req", 32'(mem_req), 1);
    tick();
    mem_gnt = 0;
    #1;
    chk("rw_stall", 32'(Stall), 1);
    rst = 1; MemoryRE = 0;
    tick();
    rst = 0;
    #1;
    chk("rw_rst_stall", 32'(Stall), 0);
    chk("rw_rst_req", 32'(mem_req), 0);
    chk("rw_rst_done", 32'(Done), 0);
    mem_rvalid = 1; mem_rdata = 32'h33333333;
    tick();
    mem_rvalid = 0;
    #1;
    chk("rw_stale_done", 32'(Done), 0);
    chk("rw_stale_stall", 32'(Stall), 0);
    access(1, 0, 3'b100, 32'h003, 32'h0, 32'h80F17F00, 0);
    chk("rw_next_data", r_ld, 32'h00000080);
    chk("rw_next_cyc", r_cyc, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
